// File: rtl/if_program_loader_if.sv
// if_program_loader_if: byte stream into the loader and instruction memory write port out of it.
interface if_program_loader_if #(
  parameter int NB_INST = 32,
  parameter int NB_ADDR = 32
);
  logic               i_rx_valid;
  logic [7:0]         i_rx_data;
  logic               o_rx_ready;
  logic               o_write;
  logic [NB_ADDR-1:0] o_address;
  logic [NB_INST-1:0] o_instruction;
  modport master (
    input  i_rx_valid, i_rx_data,
    output o_rx_ready, o_write, o_address, o_instruction
  );
  modport slave (
    output i_rx_valid, i_rx_data,
    input  o_rx_ready, o_write, o_address, o_instruction
  );
endinterface

// File: rtl/if_program_loader.sv
// if_program_loader: assembles MSB-first bytes into words and writes them to instruction memory until HALT.
// Optional LOADER_CHECKSUM_EN adds a trailing XOR checksum byte check after HALT.
module if_program_loader #(
  parameter int NB_INST   = 32,
  parameter int NB_ADDR   = 32,
  parameter int MEM_DEPTH = 256
) (
  input  logic               i_clk,
  input  logic               i_reset,
  input  logic               i_start,
  if_program_loader_if.master bus,
  output logic               o_busy,
  output logic               o_done,
  output logic               o_error,
  output logic [NB_ADDR-1:0] o_words
);
`ifdef LOADER_CHECKSUM_EN
  typedef enum logic [2:0] {IDLE, RECV, WRITE, DONE, ERROR, CHECK} state_t;
  logic [7:0] sum;
`else
  typedef enum logic [2:0] {IDLE, RECV, WRITE, DONE, ERROR} state_t;
`endif
  state_t state, state_nx;
  logic [1:0] cnt;
  logic [NB_INST-9:0] word;
  logic [NB_INST-1:0] instruction;
  logic [NB_ADDR-1:0] address, words;
  logic accept, last, halt, full, start_load;
  assign accept     = bus.i_rx_valid && bus.o_rx_ready;
  assign last       = cnt == 2'd3;
  assign halt       = instruction == '0;
  assign full       = address == NB_ADDR'(MEM_DEPTH - 1);
  assign start_load = i_start && (state == IDLE || state == DONE || state == ERROR);
  always_comb begin
    state_nx = state;
    case (state)
      IDLE, DONE, ERROR: state_nx = i_start ? RECV : state;
      RECV:              state_nx = accept && last ? WRITE : RECV;
`ifdef LOADER_CHECKSUM_EN
      WRITE:             state_nx = halt ? CHECK : full ? ERROR : RECV;
      CHECK:             state_nx = !accept ? CHECK : bus.i_rx_data == sum ? DONE : ERROR;
`else
      WRITE:             state_nx = halt ? DONE : full ? ERROR : RECV;
`endif
      default:           state_nx = IDLE;
    endcase
  end
`ifdef LOADER_CHECKSUM_EN
  assign bus.o_rx_ready = state == RECV || state == CHECK;
`else
  assign bus.o_rx_ready = state == RECV;
`endif
  assign bus.o_write       = state == WRITE;
  assign bus.o_address     = address;
  assign bus.o_instruction = instruction;
  assign o_busy            = state == RECV || state == WRITE;
  assign o_done            = state == DONE;
  assign o_error           = state == ERROR;
  assign o_words           = words;
  // instruction is loaded only on the 4th byte so it stays stable while the next word assembles
  always_ff @(posedge i_clk or posedge i_reset)
    if (i_reset) begin
      state       <= IDLE;
      cnt         <= '0;
      word        <= '0;
      instruction <= '0;
      address     <= '0;
      words       <= '0;
`ifdef LOADER_CHECKSUM_EN
      sum         <= '0;
`endif
    end else begin
      state <= state_nx;
      if (start_load) begin
        cnt     <= '0;
        address <= '0;
        words   <= '0;
`ifdef LOADER_CHECKSUM_EN
        sum     <= '0;
`endif
      end
      if (accept && state == RECV) begin
        word <= {word[NB_INST-17:0], bus.i_rx_data};
        cnt  <= cnt + 2'd1;
`ifdef LOADER_CHECKSUM_EN
        sum  <= sum ^ bus.i_rx_data;
`endif
        if (last) instruction <= {word, bus.i_rx_data};
      end
      if (state == WRITE) begin
        address <= address + 1'b1;
        words   <= words + 1'b1;
        cnt     <= '0;
      end
    end
endmodule

// File: tb/tb_if_program_loader.sv
// tb_if_program_loader: directed loads with a write scoreboard; dut0 at default depth, dut1 with MEM_DEPTH=4.
`timescale 1ns/1ps
module tb_if_program_loader;
  logic clk = 0, rst = 1, start0 = 0, start1 = 0, rx_valid = 0;
  logic [7:0] rx_data = '0;
  logic busy0, done0, error0, busy1, done1, error1;
  logic [31:0] words0, words1;
  int compared = 0, mismatched = 0, g = 0;
  logic [63:0] exp0[$], exp1[$], obs0[$], obs1[$];
  always #5 clk = ~clk;
  if_program_loader_if bus0 ();
  if_program_loader_if bus1 ();
  assign bus0.i_rx_valid = rx_valid;
  assign bus0.i_rx_data  = rx_data;
  assign bus1.i_rx_valid = rx_valid;
  assign bus1.i_rx_data  = rx_data;
  if_program_loader dut0 (.i_clk(clk), .i_reset(rst), .i_start(start0), .bus(bus0),
                          .o_busy(busy0), .o_done(done0), .o_error(error0), .o_words(words0));
  if_program_loader #(.MEM_DEPTH(4)) dut1 (.i_clk(clk), .i_reset(rst), .i_start(start1), .bus(bus1),
                          .o_busy(busy1), .o_done(done1), .o_error(error1), .o_words(words1));
  always @(negedge clk) begin
    if (bus0.o_write) obs0.push_back({bus0.o_address, bus0.o_instruction});
    if (bus1.o_write) obs1.push_back({bus1.o_address, bus1.o_instruction});
  end
  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    compared++;
    assert (got === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic score(input string tag, input bit d);
    logic [63:0] e, o;
    int n;
    n = d ? exp1.size() : exp0.size();
    for (int i = 0; i < n; i++) begin
      o = 'x;
      if (d) begin
        e = exp1.pop_front();
        if (obs1.size() > 0) o = obs1.pop_front();
      end else begin
        e = exp0.pop_front();
        if (obs0.size() > 0) o = obs0.pop_front();
      end
      check(tag, o, e);
    end
    check({tag, " extra writes"}, d ? obs1.size() : obs0.size(), 0);
  endtask
  task automatic send_byte(input logic [7:0] b, input int gap, input bit d);
    int t;
    t = 0;
    rx_valid = 0;
    repeat (gap) @(negedge clk);
    rx_valid = 1;
    rx_data  = b;
    while (!(d ? bus1.o_rx_ready : bus0.o_rx_ready) && t < 50) begin
      @(negedge clk);
      t++;
    end
    if (t == 50) begin
      compared++;
      mismatched++;
      $error("FAIL rx_ready timeout: observed 0 expected 1");
    end
    @(negedge clk);
    rx_valid = 0;
  endtask
  task automatic send_word(input logic [31:0] w, input logic [31:0] addr, input bit gaps, input bit d);
    if (d) exp1.push_back({addr, w});
    else   exp0.push_back({addr, w});
    for (int k = 3; k >= 0; k--) begin
      send_byte(w[8*k +: 8], gaps ? g % 6 : 0, d);
      g++;
    end
  endtask
  task automatic pulse_start0();
    start0 = 1;
    @(negedge clk);
    start0 = 0;
  endtask
  initial begin
    repeat (2) @(negedge clk);
    check("reset busy", busy0, 0);
    check("reset done", done0, 0);
    check("reset error", error0, 0);
    check("reset write", bus0.o_write, 0);
    check("reset ready", bus0.o_rx_ready, 0);
    check("reset address", bus0.o_address, 0);
    check("reset words", words0, 0);
    check("reset instruction", bus0.o_instruction, 0);
    rst = 0;
    @(negedge clk);
    pulse_start0();
    check("t1 busy", busy0, 1);
    check("t1 ready", bus0.o_rx_ready, 1);
    send_word(32'h00223021, 0, 0, 0);
    send_word(32'h00000000, 1, 0, 0);
`ifdef LOADER_CHECKSUM_EN
    // XOR of 00 22 30 21 00 00 00 00 is 8'h33
    send_byte(8'h33, 0, 0);
`endif
    repeat (3) @(negedge clk);
    score("t1 write", 0);
    check("t1 done", done0, 1);
    check("t1 error", error0, 0);
    check("t1 busy", busy0, 0);
    check("t1 words", words0, 2);
    check("t1 address hold", bus0.o_address, 2);
    pulse_start0();
    check("t2 done cleared", done0, 0);
    check("t2 address restart", bus0.o_address, 0);
    check("t2 words restart", words0, 0);
    check("t2 busy", busy0, 1);
    send_word(32'h00223021, 0, 1, 0);
    start0 = 1;
    repeat (2) @(negedge clk);
    start0 = 0;
    check("t2 start ignored address", bus0.o_address, 1);
    check("t2 start ignored words", words0, 1);
    check("t2 start ignored busy", busy0, 1);
    send_word(32'h00000000, 1, 1, 0);
`ifdef LOADER_CHECKSUM_EN
    send_byte(8'h33, 3, 0);
`endif
    repeat (3) @(negedge clk);
    score("t2 gapped write", 0);
    check("t2 done", done0, 1);
    check("t2 words", words0, 2);
`ifdef LOADER_CHECKSUM_EN
    pulse_start0();
    send_word(32'h00223021, 0, 0, 0);
    send_word(32'h00000000, 1, 0, 0);
    send_byte(8'h34, 0, 0);
    repeat (3) @(negedge clk);
    score("t3 bad checksum write", 0);
    check("t3 error", error0, 1);
    check("t3 done", done0, 0);
`endif
    pulse_start0();
    send_word(32'h0A0B0C0D, 0, 0, 0);
    @(negedge clk);
    score("t4 first word", 0);
    send_byte(8'h12, 0, 0);
    send_byte(8'h34, 0, 0);
    check("t4 busy before reset", busy0, 1);
    #2 rst = 1;
    #1;
    check("t4 async busy", busy0, 0);
    check("t4 async ready", bus0.o_rx_ready, 0);
    check("t4 async write", bus0.o_write, 0);
    check("t4 async done", done0, 0);
    check("t4 async error", error0, 0);
    check("t4 async address", bus0.o_address, 0);
    check("t4 async words", words0, 0);
    check("t4 async instruction", bus0.o_instruction, 0);
    @(negedge clk);
    rst = 0;
    repeat (3) @(negedge clk);
    score("t4 no write after reset", 0);
    start1 = 1;
    @(negedge clk);
    start1 = 0;
    for (int k = 0; k < 4; k++) send_word(32'h11111111 * (k + 1), k, 0, 1);
    repeat (3) @(negedge clk);
    score("t5 depth4 write", 1);
    score("t5 dut0 untouched", 0);
    check("t5 error", error1, 1);
    check("t5 busy", busy1, 0);
    check("t5 done", done1, 0);
    check("t5 words", words1, 4);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
